// File: rtl/fe_stage_pkg.sv
// fe_stage_pkg: fetch-stage widths, AGEX resolution bus and FE latch layouts
package fe_stage_pkg;
  localparam int DBITS = 32;
  localparam int INSTBITS = 32;
  localparam int GHR_BITS = 8;
  localparam int BTB_ENTRIES = 16;
  localparam int BTB_IDX_BITS = $clog2(BTB_ENTRIES);
  localparam int BTB_TAG_BITS = DBITS - BTB_IDX_BITS - 2;
  localparam logic [DBITS-1:0] START_PC = 32'h0000_0000;
  localparam int BUS_CANARY_WIDTH = 4;
  localparam logic [BUS_CANARY_WIDTH-1:0] BUS_CANARY_VALUE = 4'hD;
  localparam int from_AGEX_to_FE_WIDTH = 4 + 2 * DBITS + GHR_BITS;
  localparam int FE_latch_WIDTH = INSTBITS + 3 * DBITS + 1 + GHR_BITS + BUS_CANARY_WIDTH;
  typedef struct packed {
    logic br_valid;
    logic br_cond;
    logic br_taken;
    logic br_mispred;
    logic [DBITS-1:0] br_pc;
    logic [DBITS-1:0] br_target;
    logic [GHR_BITS-1:0] br_old_ghr;
  } agex_bus_t;
  typedef struct packed {
    logic [INSTBITS-1:0] inst;
    logic [DBITS-1:0] PC;
    logic [DBITS-1:0] pcplus;
    logic [DBITS-1:0] inst_count;
    logic prediction_flag;
    logic [GHR_BITS-1:0] old_branch_history_register;
    logic [BUS_CANARY_WIDTH-1:0] bus_canary;
  } fe_latch_t;
endpackage

// File: rtl/fe_stage_gshare_predictor.sv
// gshare_predictor: gshare PHT, direct-mapped BTB and speculative GHR with AGEX training/restore
module gshare_predictor
  import fe_stage_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DBITS-1:0]    pc,
  input  logic                advance,
  input  agex_bus_t           br,
  output logic                pred_taken,
  output logic [DBITS-1:0]    pred_target,
  output logic [GHR_BITS-1:0] ghr
);
  localparam int PHT_SIZE = 1 << GHR_BITS;
  logic [1:0] pht [PHT_SIZE];
  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [BTB_TAG_BITS-1:0] btb_tag [BTB_ENTRIES];
  logic [DBITS-1:0] btb_target [BTB_ENTRIES];
  logic [GHR_BITS-1:0] rd_idx, wr_idx;
  logic [BTB_IDX_BITS-1:0] rd_bi, wr_bi;
  logic [1:0] ctr;
  logic hit, mispred, btb_wr;
  assign rd_idx = pc[GHR_BITS+1:2] ^ ghr;
  assign rd_bi = pc[BTB_IDX_BITS+1:2];
  assign hit = btb_valid[rd_bi] && btb_tag[rd_bi] == pc[DBITS-1:BTB_IDX_BITS+2];
  assign pred_taken = hit && pht[rd_idx][1];
  assign pred_target = btb_target[rd_bi];
  assign wr_idx = br.br_pc[GHR_BITS+1:2] ^ br.br_old_ghr;
  assign wr_bi = br.br_pc[BTB_IDX_BITS+1:2];
  assign ctr = pht[wr_idx];
  assign mispred = br.br_valid && br.br_mispred;
  assign btb_wr = br.br_valid && br.br_taken;
  // Reads see pre-edge contents, so a same-cycle training write is invisible until next cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ghr <= '0;
      btb_valid <= '0;
      for (int i = 0; i < PHT_SIZE; i++) pht[i] <= 2'b01;
    end else begin
      if (mispred) ghr <= br.br_cond ? {br.br_old_ghr[GHR_BITS-2:0], br.br_taken} : br.br_old_ghr;
      else if (advance && hit) ghr <= {ghr[GHR_BITS-2:0], pred_taken};
      if (br.br_valid && br.br_cond)
        pht[wr_idx] <= br.br_taken ? (ctr == 2'b11 ? ctr : ctr + 2'd1) : (ctr == 2'b00 ? ctr : ctr - 2'd1);
      if (btb_wr) btb_valid[wr_bi] <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset_n && btb_wr) begin
      btb_tag[wr_bi] <= br.br_pc[DBITS-1:BTB_IDX_BITS+2];
      btb_target[wr_bi] <= br.br_target;
    end
  end
endmodule

// File: rtl/fe_stage.sv
// fe_stage: PC owner and instruction fetch, gshare/BTB prediction, FE latch toward decode
module fe_stage
  import fe_stage_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [INSTBITS-1:0]              imem_rdata,
  input  logic                             from_DE_to_FE,
  input  logic [from_AGEX_to_FE_WIDTH-1:0] from_AGEX_to_FE,
  output logic [DBITS-1:0]                 imem_addr,
  output logic [FE_latch_WIDTH-1:0]        FE_latch_out
);
  agex_bus_t br;
  fe_latch_t latch;
  logic [DBITS-1:0] pc, pcplus, inst_count, pred_target;
  logic [GHR_BITS-1:0] ghr;
  logic stall, mispred, pred_taken;
  assign br = agex_bus_t'(from_AGEX_to_FE);
  assign stall = from_DE_to_FE;
  assign mispred = br.br_valid && br.br_mispred;
  assign pcplus = pc + 32'd4;
  assign imem_addr = pc;
  assign FE_latch_out = latch;
  gshare_predictor u_pred (
    .clk(clk),
    .reset_n(reset_n),
    .pc(pc),
    .advance(!stall),
    .br(br),
    .pred_taken(pred_taken),
    .pred_target(pred_target),
    .ghr(ghr)
  );
  // Redirect wins over stall: the bubble replaces whatever decode was holding
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc <= START_PC;
      inst_count <= '0;
      latch <= '0;
    end else if (mispred) begin
      pc <= br.br_taken ? br.br_target : br.br_pc + 32'd4;
      latch <= '0;
    end else if (!stall) begin
      latch <= '{imem_rdata, pc, pcplus, inst_count, pred_taken, ghr, BUS_CANARY_VALUE};
      inst_count <= inst_count + 32'd1;
      pc <= pred_taken ? pred_target : pcplus;
    end
  end
endmodule

// File: tb/tb_fe_stage.sv
// tb_fe_stage: directed checks of fetch, stall, redirect, gshare training and GHR restore
module tb_fe_stage;
  import fe_stage_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic stall = 1'b0;
  logic [31:0] imem_rdata = 32'h0000_0013;
  logic [31:0] imem_addr;
  agex_bus_t agex = '0;
  logic [FE_latch_WIDTH-1:0] fe_out;
  fe_latch_t lat;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  assign lat = fe_latch_t'(fe_out);
  fe_stage dut (
    .clk(clk),
    .reset_n(reset_n),
    .imem_rdata(imem_rdata),
    .from_DE_to_FE(stall),
    .from_AGEX_to_FE(agex),
    .imem_addr(imem_addr),
    .FE_latch_out(fe_out)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive_br(input logic cond, input logic taken, input logic mis,
                          input logic [31:0] pc, input logic [31:0] tgt, input logic [7:0] g);
    agex = '{1'b1, cond, taken, mis, pc, tgt, g};
  endtask
  task automatic fetch_chk(input string tag, input logic [31:0] pc, input logic [31:0] cnt);
    chk({tag, "_pc"}, lat.PC, pc);
    chk({tag, "_pcplus"}, lat.pcplus, pc + 32'd4);
    chk({tag, "_cnt"}, lat.inst_count, cnt);
  endtask
  task automatic redirect40(input string tag, input logic flag, input logic [31:0] nxt);
    drive_br(1'b0, 1'b0, 1'b1, 32'h3C, 32'h0, 8'h00);
    tick;
    agex = '0;
    chk({tag, "_redir_addr"}, imem_addr, 32'h40);
    tick;
    chk({tag, "_pc"}, lat.PC, 32'h40);
    chk({tag, "_flag"}, lat.prediction_flag, flag);
    chk({tag, "_ghr"}, lat.old_branch_history_register, 8'h00);
    chk({tag, "_next"}, imem_addr, nxt);
  endtask
  initial begin
    tick;
    tick;
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_latch", fe_out == '0, 1'b1);
    reset_n = 1'b1;
    tick;
    fetch_chk("f0", 32'h0, 32'd0);
    chk("f0_inst", lat.inst, 32'h13);
    chk("f0_flag", lat.prediction_flag, 1'b0);
    chk("f0_ghr", lat.old_branch_history_register, 8'h00);
    chk("f0_canary", lat.bus_canary, 4'hD);
    chk("f0_addr", imem_addr, 32'h4);
    tick;
    fetch_chk("f1", 32'h4, 32'd1);
    tick;
    fetch_chk("f2", 32'h8, 32'd2);
    tick;
    fetch_chk("f3", 32'hC, 32'd3);
    chk("f3_addr", imem_addr, 32'h10);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_pc", lat.PC, 32'hC);
      chk("stall_addr", imem_addr, 32'h10);
    end
    stall = 1'b0;
    tick;
    fetch_chk("unstall", 32'h10, 32'd4);
    stall = 1'b1;
    drive_br(1'b0, 1'b1, 1'b1, 32'h14, 32'h200, 8'h00);
    tick;
    chk("mis_stall_bubble", fe_out == '0, 1'b1);
    chk("mis_stall_addr", imem_addr, 32'h200);
    agex = '0;
    stall = 1'b0;
    drive_br(1'b1, 1'b1, 1'b0, 32'h40, 32'h80, 8'h00);
    tick;
    tick;
    agex = '0;
    redirect40("train", 1'b1, 32'h80);
    drive_br(1'b1, 1'b1, 1'b0, 32'h40, 32'h80, 8'h00);
    repeat (3) tick;
    drive_br(1'b1, 1'b0, 1'b0, 32'h40, 32'h80, 8'h00);
    tick;
    agex = '0;
    redirect40("sat_10", 1'b1, 32'h80);
    drive_br(1'b1, 1'b0, 1'b0, 32'h40, 32'h80, 8'h00);
    repeat (3) tick;
    agex = '0;
    redirect40("sat_00", 1'b0, 32'h44);
    drive_br(1'b1, 1'b1, 1'b0, 32'h40, 32'h80, 8'h00);
    tick;
    agex = '0;
    redirect40("sat_01", 1'b0, 32'h44);
    drive_br(1'b1, 1'b1, 1'b0, 32'h40, 32'h80, 8'h00);
    tick;
    agex = '0;
    redirect40("sat_10b", 1'b1, 32'h80);
    drive_br(1'b1, 1'b1, 1'b1, 32'h100, 32'h300, 8'hA5);
    tick;
    agex = '0;
    chk("ghr_cond_addr", imem_addr, 32'h300);
    tick;
    chk("ghr_cond_pc", lat.PC, 32'h300);
    chk("ghr_cond", lat.old_branch_history_register, 8'h4B);
    drive_br(1'b0, 1'b1, 1'b1, 32'h104, 32'h400, 8'h3C);
    tick;
    agex = '0;
    chk("ghr_jalr_addr", imem_addr, 32'h400);
    tick;
    chk("ghr_jalr_pc", lat.PC, 32'h400);
    chk("ghr_jalr", lat.old_branch_history_register, 8'h3C);
    stall = 1'b1;
    drive_br(1'b0, 1'b1, 1'b1, 32'h0, 32'h500, 8'h00);
    reset_n = 1'b0;
    tick;
    chk("rst_mid_addr", imem_addr, 32'h0);
    chk("rst_mid_latch", fe_out == '0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
